// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_pkg
// Purpose : Shared types and widths for the instruction-fetch stage.
//           fetch_state_t : fetch FSM encoding (IDLE / WAIT)
//           PC_W, INSTR_W : address and instruction word widths
//           NOP_INSTR     : value of an empty / bubble instruction word
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,  // no request outstanding; may issue
    WAIT = 1'b1   // one request outstanding; waiting for rvalid
  } fetch_state_t;

endpackage : if_fetch_unit_pkg
`default_nettype wire

// File: rtl/if_fetch_unit_buffer.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_buffer
// Purpose : One-entry {valid, pc, instr} holding register between the
//           instruction memory response and the IF/ID register.
// Ports   : clk_i    in  clock
//           rst_i    in  synchronous active-high reset (empties, zeroes data)
//           load_i   in  capture pc_i/instr_i and mark valid
//           clear_i  in  mark empty (data fields keep their last value)
//           pc_i     in  PC of the instruction being loaded
//           instr_i  in  instruction word being loaded
//           valid_o  out entry holds an unconsumed instruction
//           pc_o     out stored PC
//           instr_o  out stored instruction word
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit_buffer
  import if_fetch_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Load wins over clear: a fresh response must never be lost to a
  // same-cycle consume of the (already empty) entry.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule : if_fetch_unit_buffer
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit
// Purpose : Instruction-fetch stage feeding the IF/ID pipeline register.
//           Owns the PC, issues one request at a time to a variable-latency
//           instruction memory, buffers one returned instruction and drives
//           pc4/instr plus write-enable/flush into IF/ID.
// Ports   : clk_i, rst_i         clock / synchronous active-high reset
//           pc_write_i           1 = downstream may advance, 0 = stall
//           branch_taken_i       redirect pulse from ID
//           branch_target_i      redirect address (low two bits ignored)
//           imem_req_o/addr_o    fetch request strobe and address
//           imem_rvalid_i/rdata_i memory response
//           pc4_o, instr_o       buffered PC+PC_STEP and instruction word
//           ifid_write_o         IF/ID write enable
//           if_flush_o           IF/ID flush (zero bubble)
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pc_write_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]    pc4_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               ifid_write_o,
  output logic               if_flush_o
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;

  logic               buf_valid;
  logic [PC_W-1:0]    buf_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic               buf_load;
  logic               buf_clear;

  logic issue;
  logic rsp_done;

  // Low target bits are forced to zero; keep them visibly consumed.
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  // A redirect suppresses issue so the first fetch after it uses the new PC.
  assign issue    = (state_q == IDLE) && !branch_taken_i && (!buf_valid || pc_write_i);
  // Responses only count while a request is outstanding.
  assign rsp_done = (state_q == WAIT) && imem_rvalid_i;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state and PC / kill bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;

    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else if (branch_taken_i) begin
          // The in-flight response now belongs to a squashed path.
          kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides any sequential PC advance.
    if (branch_taken_i) begin
      pc_d = {branch_target_i[PC_W-1:2], 2'b00};
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = (state_q == IDLE) ? pc_q : req_pc_q;
  end

  // --------------------------------------------------------------------------
  // Single-entry instruction buffer
  // --------------------------------------------------------------------------
  assign buf_load  = rsp_done && !kill_q && !branch_taken_i;
  assign buf_clear = branch_taken_i || (buf_valid && pc_write_i);

  if_fetch_unit_buffer u_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem_rdata_i),
    .valid_o (buf_valid),
    .pc_o    (buf_pc),
    .instr_o (buf_instr)
  );

  // --------------------------------------------------------------------------
  // IF/ID interface
  // --------------------------------------------------------------------------
  assign pc4_o        = buf_pc + PC_STEP;
  assign instr_o      = buf_instr;
  assign ifid_write_o = pc_write_i | branch_taken_i;
  // An empty buffer under pc_write presents a bubble rather than stale data.
  assign if_flush_o   = branch_taken_i | (pc_write_i & !buf_valid);

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_unit
// Purpose : Directed self-checking bench for if_fetch_unit. A small
//           fixed-latency responder answers requests with {16'hC0DE, addr[15:0]}
//           when enabled; otherwise responses are driven by hand.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_write_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc4_o;
  logic [31:0] instr_o;
  logic        ifid_write_o;
  logic        if_flush_o;

  int n_vec = 0;
  int n_err = 0;

  // responder state
  bit          auto_rsp = 1'b0;
  int          lat      = 1;
  bit          pend     = 1'b0;
  int          cnt      = 0;
  logic [31:0] paddr    = '0;

  always #5 clk_i = ~clk_i;

  if_fetch_unit dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_write_i      (pc_write_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .pc4_o           (pc4_o),
    .instr_o         (instr_o),
    .ifid_write_o    (ifid_write_o),
    .if_flush_o      (if_flush_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the responder notes a request seen this cycle and
  // raises rvalid 'lat' cycles later. Returns 1 ns after the edge.
  task automatic tick();
    #1;
    if (rst_i) begin
      pend = 1'b0;
    end else if (auto_rsp && imem_req_o) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_addr_o;
    end
    @(posedge clk_i);
    #1;
    imem_rvalid_i = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = {16'hC0DE, paddr[15:0]};
        pend          = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i           = 1'b1;
    pc_write_i      = 1'b1;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    imem_rvalid_i   = 1'b0;
    imem_rdata_i    = '0;
    auto_rsp        = 1'b1;
    lat             = 1;
    tick();
    tick();
    rst_i = 1'b0;

    // ---- 1: reset state and sequential fetch, latency 1 ----
    #1;
    chk("rst_req",   {31'd0, imem_req_o},   32'd1);
    chk("rst_addr",  imem_addr_o,           32'h0);
    chk("rst_pc4",   pc4_o,                 32'h4);
    chk("rst_instr", instr_o,               32'h0);
    chk("rst_wr",    {31'd0, ifid_write_o}, 32'd1);
    chk("rst_flush", {31'd0, if_flush_o},   32'd1);
    tick();
    #1;
    chk("w0_req",  {31'd0, imem_req_o}, 32'd0);
    chk("w0_addr", imem_addr_o,         32'h0);
    tick();
    #1;
    chk("s1_addr",  imem_addr_o,         32'h4);
    chk("s1_req",   {31'd0, imem_req_o}, 32'd1);
    chk("s1_instr", instr_o,             32'hC0DE_0000);
    chk("s1_pc4",   pc4_o,               32'h4);
    chk("s1_flush", {31'd0, if_flush_o}, 32'd0);
    tick();
    #1;
    chk("w1_bubble", {31'd0, if_flush_o}, 32'd1);
    tick();
    #1;
    chk("s2_addr",  imem_addr_o, 32'h8);
    chk("s2_instr", instr_o,     32'hC0DE_0004);
    chk("s2_pc4",   pc4_o,       32'h8);
    tick();
    tick();

    // ---- 2: stall three cycles with a full buffer ----
    pc_write_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_req",   {31'd0, imem_req_o},   32'd0);
      chk("st_wr",    {31'd0, ifid_write_o}, 32'd0);
      chk("st_flush", {31'd0, if_flush_o},   32'd0);
      chk("st_instr", instr_o,               32'hC0DE_0008);
      chk("st_pc4",   pc4_o,                 32'hC);
      tick();
    end
    pc_write_i = 1'b1;
    #1;
    chk("res_req",  {31'd0, imem_req_o}, 32'd1);
    chk("res_addr", imem_addr_o,         32'hC);
    tick();
    tick();
    #1;
    chk("res2_instr", instr_o,     32'hC0DE_000C);
    chk("res2_pc4",   pc4_o,       32'h10);
    chk("res2_addr",  imem_addr_o, 32'h10);

    // ---- 3: redirect during WAIT, late response dropped ----
    auto_rsp = 1'b0;
    tick();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0103;
    #1;
    chk("br_flush", {31'd0, if_flush_o},   32'd1);
    chk("br_wr",    {31'd0, ifid_write_o}, 32'd1);
    chk("br_req",   {31'd0, imem_req_o},   32'd0);
    tick();
    branch_taken_i = 1'b0;
    #1;
    chk("br_w2_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    chk("br_w3_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    #1;
    chk("br_tgt_req",   {31'd0, imem_req_o}, 32'd1);
    chk("br_tgt_addr",  imem_addr_o,         32'h100);
    chk("br_drop",      instr_o,             32'hC0DE_000C);
    chk("br_drop_flush", {31'd0, if_flush_o}, 32'd1);

    // ---- 4: redirect coincident with rvalid ----
    tick();
    imem_rvalid_i   = 1'b1;
    imem_rdata_i    = 32'h1111_1111;
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0200;
    #1;
    chk("co_flush", {31'd0, if_flush_o}, 32'd1);
    tick();
    branch_taken_i = 1'b0;
    #1;
    chk("co_req",   {31'd0, imem_req_o}, 32'd1);
    chk("co_addr",  imem_addr_o,         32'h200);
    chk("co_instr", instr_o,             32'hC0DE_000C);

    // ---- 5: latency 3, bubbles while buffer empty ----
    auto_rsp = 1'b1;
    lat      = 3;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("l3_flush", {31'd0, if_flush_o},   32'd1);
      chk("l3_wr",    {31'd0, ifid_write_o}, 32'd1);
      chk("l3_req",   {31'd0, imem_req_o},   32'd0);
      tick();
    end
    #1;
    chk("l3_instr", instr_o,             32'hC0DE_0200);
    chk("l3_pc4",   pc4_o,               32'h204);
    chk("l3_flush0", {31'd0, if_flush_o}, 32'd0);
    chk("l3_addr",  imem_addr_o,         32'h204);

    // ---- 6: reset mid-WAIT, stray rvalid ignored ----
    auto_rsp = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i         = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBAD0_BAD0;
    #1;
    chk("rw_req",   {31'd0, imem_req_o}, 32'd1);
    chk("rw_addr",  imem_addr_o,         32'h0);
    chk("rw_instr", instr_o,             32'h0);
    tick();
    #1;
    chk("rw_stray_flush", {31'd0, if_flush_o}, 32'd1);
    chk("rw_stray_instr", instr_o,             32'h0);

    // ---- 6b: PC wrap at 0xFFFF_FFFC ----
    branch_taken_i  = 1'b1;
    branch_target_i = 32'hFFFF_FFFF;
    tick();
    branch_taken_i = 1'b0;
    imem_rvalid_i  = 1'b1;
    imem_rdata_i   = 32'h2222_2222;
    tick();
    #1;
    chk("wr_addr",  imem_addr_o, 32'hFFFF_FFFC);
    chk("wr_drop",  instr_o,     32'h0);
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hC0DE_FFFC;
    tick();
    #1;
    chk("wr_pc4",   pc4_o,       32'h0);
    chk("wr_instr", instr_o,     32'hC0DE_FFFC);
    chk("wr_next",  imem_addr_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_if_fetch_unit
`default_nettype wire
